// File: rtl/log2_iter.sv
// Iterative base-2 logarithm: MSB index as integer part, fractional bits by
// repeated squaring of the normalised mantissa with a serial shift-add squarer.
module log2_iter #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 16,
    localparam int IW   = $clog2(WIDTH),
    localparam int FW   = (FRAC > 0) ? FRAC : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic             err_o,
    output logic [IW-1:0]    int_o,
    output logic [FW-1:0]    frac_o
);
    localparam int KW = $clog2(FRAC + 2);

    typedef enum logic [2:0] {IDLE, NORM, SQUARE, CHECK, DONE} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     m_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [IW-1:0]        cnt_q;
    logic [KW-1:0]        k_q;
    logic [IW-1:0]        int_q;
    logic [FW-1:0]        frac_q;
    logic                 err_q;
    logic                 valid_q;
    logic                 busy_q;

    logic [IW-1:0]        msb_d;
    logic [WIDTH-1:0]     mant_d;
    logic [2*WIDTH-1:0]   pp_d;
    logic [2*WIDTH-1:0]   psum_d;
    logic                 top_d;
    logic [WIDTH-1:0]     mnext_d;

    always_comb begin
        msb_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (opnd_q[i]) msb_d = IW'(i);
        end
    end

    // m_q is Q1.(WIDTH-1); its square p_q is Q2.(2*WIDTH-2).
    always_comb begin
        mant_d  = opnd_q << (IW'(WIDTH - 1) - msb_d);
        pp_d    = {{WIDTH{1'b0}}, m_q} << cnt_q;
        psum_d  = m_q[cnt_q] ? (p_q + pp_d) : p_q;
        top_d   = p_q[2*WIDTH-1];
        mnext_d = top_d ? p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-2:WIDTH-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            int_q   <= '0;
            frac_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start_i) begin
                        opnd_q  <= data_i;
                        frac_q  <= '0;
                        err_q   <= 1'b0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    p_q   <= '0;
                    cnt_q <= '0;
                    if (opnd_q == '0) begin
                        err_q   <= 1'b1;
                        int_q   <= '0;
                        frac_q  <= '0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        int_q <= msb_d;
                        m_q   <= mant_d;
                        if (FRAC == 0) begin
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= SQUARE;
                        end
                    end
                end
                SQUARE: begin
                    p_q   <= psum_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IW'(WIDTH - 1)) state_q <= CHECK;
                end
                CHECK: begin
                    m_q    <= mnext_d;
                    frac_q <= (frac_q << 1) | FW'(top_d);
                    k_q    <= k_q + 1'b1;
                    p_q    <= '0;
                    cnt_q  <= '0;
                    if (k_q == KW'(FRAC - 1)) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= SQUARE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign int_o   = int_q;
    assign frac_o  = frac_q;
endmodule

// File: tb/tb_log2_iter.sv
// Bench for log2_iter: directed and random operands against a plain-arithmetic
// repeated-squaring model, plus a WIDTH=8/FRAC=4 instance.
module tb_log2_iter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] data;
    logic        busy, valid, err;
    logic [3:0]  int_o;
    logic [15:0] frac;

    logic        start8;
    logic [7:0]  data8;
    logic        busy8, valid8, err8;
    logic [2:0]  int8;
    logic [3:0]  frac8;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    log2_iter #(.WIDTH(16), .FRAC(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(data),
        .busy_o(busy), .valid_o(valid), .err_o(err), .int_o(int_o), .frac_o(frac)
    );

    log2_iter #(.WIDTH(8), .FRAC(4)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .data_i(data8),
        .busy_o(busy8), .valid_o(valid8), .err_o(err8), .int_o(int8), .frac_o(frac8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // log2 of x: integer part is the top set bit; each fractional bit is
    // whether the squared mantissa reaches 2.0, truncating to 16 bits.
    task automatic ref_log2(input logic [15:0] x, output int ip, output logic [15:0] fp,
                            output logic e);
        longint m, p;
        ip = 0; fp = '0; e = (x == 0);
        if (e) return;
        for (int i = 0; i < 16; i++) if (x[i]) ip = i;
        m = longint'(x) << (15 - ip);
        for (int k = 0; k < 16; k++) begin
            p = m * m;
            if (p >= (64'd1 << 31)) begin
                fp = {fp[14:0], 1'b1};
                m  = p >> 16;
            end else begin
                fp = {fp[14:0], 1'b0};
                m  = p >> 15;
            end
        end
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (valid) return;
        end
        compared++;
        mismatched++;
        $error("FAIL timeout: valid_o not seen within 400 edges");
    endtask

    task automatic check_result(input string tag, input logic [15:0] d, input int n);
        int ip; logic [15:0] fp; logic e;
        ref_log2(d, ip, fp, e);
        chk({tag, "_lat"},  n, e ? 2 : 274);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_err"},  err, e);
        chk({tag, "_int"},  int_o, ip[3:0]);
        chk({tag, "_frac"}, frac, fp);
    endtask

    task automatic run16(input string tag, input logic [15:0] d);
        int n;
        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(posedge clk);
        #1 start = 1'b0;
        wait_valid(n);
        check_result(tag, d, n);
        @(posedge clk);
        #1;
        chk({tag, "_vfall"}, valid, 1'b0);
        chk({tag, "_bfall"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        logic [15:0] a, b, d;
        rst_n = 1'b0; start = 1'b0; data = '0; start8 = 1'b0; data8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_int", int_o, 4'd0);
        chk("rst_frac", frac, 16'd0);
        @(negedge clk) rst_n = 1'b1;

        run16("one", 16'h0001);
        chk("one_frac_const", frac, 16'h0000);
        run16("msb15", 16'h8000);
        chk("msb15_int_const", int_o, 4'd15);
        run16("five", 16'h0005);
        chk("five_int_const", int_o, 4'd2);
        chk("five_hi", frac[15:8], 8'h52);
        run16("twelve", 16'h000C);
        chk("twelve_int_const", int_o, 4'd3);
        chk("twelve_hi", frac[15:8], 8'h95);
        run16("zero", 16'h0000);
        chk("zero_err_const", err, 1'b1);
        run16("two", 16'h0002);
        chk("two_err_clr", err, 1'b0);
        chk("two_int_const", int_o, 4'd1);
        chk("hold_int", int_o, 4'd1);

        for (int i = 0; i < 12; i++) begin
            d = 16'($urandom) >> $urandom_range(0, 15);
            run16("rand", d);
        end

        // start held high through a whole op while the operand keeps changing
        a = 16'($urandom) | 16'h0100;
        b = 16'($urandom) | 16'h0001;
        @(negedge clk);
        start = 1'b1;
        data  = a;
        @(posedge clk);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk) data = 16'($urandom);
            @(posedge clk);
            n++;
            #1;
            if (valid) break;
        end
        check_result("held", a, n);
        @(negedge clk) data = b;
        @(posedge clk);
        #1;
        chk("held_vfall", valid, 1'b0);
        chk("held_bfall", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("held_reaccept", busy, 1'b1);
        start = 1'b0;
        wait_valid(n);
        check_result("held2", b, n);
        @(posedge clk);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1;
        data  = 16'h1234;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_valid", valid, 1'b0);
        chk("mid_err", err, 1'b0);
        chk("mid_int", int_o, 4'd0);
        chk("mid_frac", frac, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run16("after_rst", 16'h0777);

        // WIDTH=8, FRAC=4 instance
        @(negedge clk);
        start8 = 1'b1;
        data8  = 8'd6;
        @(posedge clk);
        #1 start8 = 1'b0;
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (valid8) break;
        end
        chk("w8_lat", n, 38);
        chk("w8_valid", valid8, 1'b1);
        chk("w8_int", int8, 3'd2);
        chk("w8_frac", frac8, 4'b1001);
        chk("w8_err", err8, 1'b0);
        @(posedge clk);
        #1;
        chk("w8_bfall", busy8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
